mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch path (PC-addressed) and the data path (TR-addressed loads/stores) of the multicycle CPU.
- Each requester holds a request until it receives a one-cycle done pulse. The arbiter sequences fixed-latency memory accesses and returns read data in per-requester holding registers.
- Data accesses have priority. A starvation guard guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Data wins ties; after STARVE_MAX consecutive contested data grants, fetch is forced through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT  = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_DM     = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wait_q, wait_d;
  logic [3:0]          starve_q, starve_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm_s;

  // State and grant registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wait_q     <= 4'd0;
      starve_q   <= 4'd0;
      if_rdata_q <= {DATA_W{1'b0}};
      dm_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state, grant selection and read-data capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          grant_dm_s = dm_req && !(if_req && (starve_q == STARVE_LIM));
          owner_d    = grant_dm_s;
          addr_d     = grant_dm_s ? dm_addr : if_addr;
          we_d       = grant_dm_s && dm_we;
          wdata_d    = grant_dm_s ? dm_wdata : {DATA_W{1'b0}};
          wait_d     = WAIT_INIT;
          state_d    = S_ACCESS;
          // Only a data grant that beats a waiting fetch counts toward starvation.
          if (grant_dm_s && if_req) begin
            starve_d = (starve_q == 4'd15) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wait_q == 4'd0) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory strobes and handshake outputs decoded from registered state only.
  always_comb begin
    busy      = 1'b0;
    owner     = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    case (state_q)
      S_ACCESS: begin
        busy      = 1'b1;
        owner     = owner_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = (owner_q == OWN_IF) || !we_q;
        mem_write = (owner_q == OWN_DM) && we_q;
      end
      S_DONE: begin
        busy    = 1'b1;
        owner   = owner_q;
        if_done = (owner_q == OWN_IF);
        dm_done = (owner_q == OWN_DM);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (cycle index within a transaction, grant rule, memory image).
module tb_mem_port_arbiter;
  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int LAT  = 3;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_done, dm_req, dm_we, dm_done;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, busy, owner;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  int            m_t;
  bit            m_own, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd, m_if_rd, m_dm_rd;
  int            m_starve;
  bit            hold_mode, rel_if, rel_dm;
  bit            grants_seen[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_starve = 0; m_if_rd = 8'h00; m_dm_rd = 8'h00;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    mem[a] = v; ref_mem[a] = v;
  endtask

  // Advance the model across the coming rising edge, using the inputs now applied.
  task automatic model_edge();
    bit g_dm;
    if (m_t == 0) begin
      if (if_req || dm_req) begin
        g_dm    = dm_req && !(if_req && m_starve == SMAX);
        m_own   = g_dm;
        m_addr  = g_dm ? dm_addr : if_addr;
        m_we    = g_dm && dm_we;
        m_wdata = dm_wdata;
        m_rd    = ref_mem[m_addr];
        if (m_we) ref_mem[m_addr] = dm_wdata;
        if (g_dm && if_req) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else m_starve = 0;
        m_t = 1;
      end
    end else if (m_t <= LAT) begin
      if (m_t == LAT && !m_we) begin
        if (m_own) m_dm_rd = m_rd;
        else m_if_rd = m_rd;
      end
      m_t++;
    end else begin
      m_t = 0;
    end
  endtask

  task automatic check_cycle();
    logic [5:0]    exp_ctl;
    logic [AW-1:0] exp_addr;
    if (m_t == 0) begin
      exp_ctl = 6'b000000; exp_addr = 13'h0000;
    end else if (m_t <= LAT) begin
      exp_ctl = {1'b1, m_own, !m_we, m_we, 2'b00}; exp_addr = m_addr;
    end else begin
      exp_ctl = {1'b1, m_own, 2'b00, !m_own, m_own}; exp_addr = 13'h0000;
    end
    chk("ctl{busy,owner,rd,wr,ifd,dmd}", 32'({busy, owner, mem_read, mem_write, if_done, dm_done}), 32'(exp_ctl));
    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (m_t >= 1 && m_t <= LAT && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("if_rdata", 32'(if_rdata), 32'(m_if_rd));
    chk("dm_rdata", 32'(dm_rdata), 32'(m_dm_rd));
    if (m_t == 1) grants_seen.push_back(owner);
  endtask

  // One clock: model edge, sample at the falling edge, emulate memory and requesters.
  task automatic step();
    model_edge();
    @(negedge clk);
    check_cycle();
    if (mem_write) mem[mem_addr] = mem_wdata;
    rel_if = 1'b0; rel_dm = 1'b0;
    if (if_done) begin
      if (hold_mode) if_addr = 13'($urandom);
      else begin if_req = 1'b0; rel_if = 1'b1; end
    end
    if (dm_done) begin
      if (hold_mode) begin dm_addr = 13'($urandom); dm_we = 1'b0; end
      else begin dm_req = 1'b0; rel_dm = 1'b1; end
    end
  endtask

  task automatic wait_done(input bit which, input string tag, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    while (!got && lat < 4 * LAT + 20) begin
      step(); lat++;
      got = which ? dm_done : if_done;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((if_req || dm_req || m_t != 0) && n < 200) begin step(); n++; end
    chk("drain_idle", 32'(m_t != 0 || if_req || dm_req), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit exp_pat [6];
    int n;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 13'h0000; dm_addr = 13'h0000; dm_wdata = 8'h00;
    hold_mode = 1'b0; rel_if = 1'b0; rel_dm = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_ctl", 32'({busy, owner, mem_read, mem_write, if_done, dm_done}), 32'd0);
    chk("reset_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("reset_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    rst = 1'b0;

    // Single fetch.
    poke(13'h0005, 8'hA7);
    if_addr = 13'h0005; if_req = 1'b1;
    step();
    chk("fetch_strobe", 32'({mem_read, mem_write, mem_addr}), 32'({1'b1, 1'b0, 13'h0005}));
    wait_done(1'b0, "fetch", lat);
    chk("fetch_latency", 32'(lat), 32'(LAT));
    chk("fetch_rdata", 32'(if_rdata), 32'h0000_00A7);
    chk("fetch_no_dm_done", 32'(dm_done), 32'd0);
    step();

    // Data write at top of the address range.
    dm_addr = 13'h1FFF; dm_we = 1'b1; dm_wdata = 8'h3C; dm_req = 1'b1;
    step();
    chk("write_strobe", 32'({mem_read, mem_write}), 32'b01);
    wait_done(1'b1, "write", lat);
    chk("write_latency", 32'(lat), 32'(LAT));
    chk("write_mem", 32'(mem[13'h1FFF]), 32'h0000_003C);
    chk("write_dm_rdata_held", 32'(dm_rdata), 32'd0);
    step();

    // Both requesters continuously busy: data, data, fetch repeating.
    grants_seen.delete();
    hold_mode = 1'b1;
    if_addr = 13'($urandom); dm_addr = 13'($urandom); dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    n = 0;
    while (grants_seen.size() < 6 && n < 200) begin step(); n++; end
    hold_mode = 1'b0;
    chk("starve_grant_count", 32'(grants_seen.size() >= 6), 32'd1);
    exp_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) chk($sformatf("starve_grant%0d", k), 32'(grants_seen[k]), 32'(exp_pat[k]));
    drain();

    // Data request raised while a fetch is in ACCESS.
    if_addr = 13'h0042; if_req = 1'b1;
    step();
    dm_addr = 13'h0043; dm_we = 1'b0; dm_req = 1'b1;
    wait_done(1'b0, "busy_fetch", lat);
    chk("busy_fetch_first", 32'(dm_done), 32'd0);
    step();
    chk("busy_idle_gap", 32'(busy), 32'd0);
    step();
    chk("busy_data_grant", 32'({busy, owner}), 32'b11);
    wait_done(1'b1, "busy_data", lat);
    step();

    // Reset in the middle of a write.
    dm_addr = 13'h0ABC; dm_we = 1'b1; dm_wdata = 8'h5A; dm_req = 1'b1;
    step(); step();
    chk("prerst_write", 32'(mem_write), 32'd1);
    #2 rst = 1'b1; dm_req = 1'b0;
    #1;
    chk("rst_async_ctl", 32'({busy, owner, mem_read, mem_write, if_done, dm_done}), 32'd0);
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    model_reset();
    @(negedge clk);
    chk("rst_no_done", 32'({if_done, dm_done}), 32'd0);
    chk("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    rst = 1'b0;
    if_addr = 13'h0ABC; if_req = 1'b1;
    step();
    wait_done(1'b0, "post_rst_fetch", lat);
    chk("post_rst_fetch_rdata", 32'(if_rdata), 32'h0000_005A);
    step();

    // Held read data across other requesters' traffic.
    poke(13'h0100, 8'h11); poke(13'h0200, 8'h22);
    dm_addr = 13'h0100; dm_we = 1'b0; dm_req = 1'b1;
    wait_done(1'b1, "held_read", lat);
    step();
    chk("held_dm_read", 32'(dm_rdata), 32'h0000_0011);
    if_addr = 13'h0200; if_req = 1'b1;
    wait_done(1'b0, "held_fetch", lat);
    step();
    chk("held_if_rdata", 32'(if_rdata), 32'h0000_0022);
    dm_addr = 13'h0300; dm_we = 1'b1; dm_wdata = 8'h55; dm_req = 1'b1;
    wait_done(1'b1, "held_write", lat);
    step();
    chk("held_dm_after_write", 32'(dm_rdata), 32'h0000_0011);
    chk("held_if_after_write", 32'(if_rdata), 32'h0000_0022);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!if_req && !rel_if && $urandom_range(99, 0) < 40) begin
        if_addr = 13'($urandom); if_req = 1'b1;
      end
      if (!dm_req && !rel_dm && $urandom_range(99, 0) < 50) begin
        dm_addr = 13'($urandom_range(63, 0)); dm_we = 1'($urandom);
        dm_wdata = 8'($urandom); dm_req = 1'b1;
      end
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
